// File: rtl/banded_tile_stream_sequencer.sv
// Captures one ROWS x COLS tile and serialises it over valid/ready in banded
// column-major order: upper band (rows 0..SUB_ROWS-1) first, then lower band.
module banded_tile_stream_sequencer #(
  parameter int BIT_WIDTH = 4,
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int SUB_ROWS  = 4,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ROWS*COLS*BIT_WIDTH-1:0] in_flat,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [BIT_WIDTH-1:0]           out_data,
  output logic [RW-1:0]                  out_row,
  output logic [CW-1:0]                  out_col,
  output logic                           out_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           busy
);

  if (SUB_ROWS < 1 || SUB_ROWS > ROWS) begin : g_bad_sub_rows
    $error("SUB_ROWS must lie in 1..ROWS");
  end

  localparam bit            SINGLE_BAND = (SUB_ROWS == ROWS);
  localparam logic [RW-1:0] SUB_LAST    = RW'(SUB_ROWS - 1);
  localparam logic [RW-1:0] SUB_FIRST   = RW'(SUB_ROWS % ROWS);
  localparam logic [RW-1:0] ROW_LAST    = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST    = CW'(COLS - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                         state_reg, state_next;
  logic [RW-1:0]                  row_reg, row_next;
  logic [CW-1:0]                  col_reg, col_next;
  logic                           band_reg, band_next;
  logic                           capture;
  logic                           last_beat;
  logic [ROWS*COLS*BIT_WIDTH-1:0] tile_reg;
  logic [BIT_WIDTH-1:0]           elem [ROWS][COLS];

  // Unpacked view of the held tile so the output mux indexes by (row, col).
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_col
      assign elem[gi][gj] = tile_reg[(gi*COLS+gj)*BIT_WIDTH +: BIT_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      row_reg   <= '0;
      col_reg   <= '0;
      band_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      row_reg   <= row_next;
      col_reg   <= col_next;
      band_reg  <= band_next;
    end
  end

  // Tile storage needs no reset: it is only observed while streaming.
  always_ff @(posedge clk) begin
    if (capture) begin
      tile_reg <= in_flat;
    end
  end

  assign last_beat = (state_reg == STREAM) && (col_reg == COL_LAST) &&
                     (band_reg ? (row_reg == ROW_LAST)
                               : (SINGLE_BAND && (row_reg == SUB_LAST)));

  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    col_next   = col_reg;
    band_next  = band_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          capture    = 1'b1;
          row_next   = '0;
          col_next   = '0;
          band_next  = 1'b0;
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (last_beat) begin
            state_next = IDLE;
            row_next   = '0;
            col_next   = '0;
            band_next  = 1'b0;
          end else if (!band_reg) begin
            if (row_reg == SUB_LAST) begin
              row_next = '0;
              if (col_reg == COL_LAST) begin
                band_next = 1'b1;
                row_next  = SUB_FIRST;
                col_next  = '0;
              end else begin
                col_next = col_reg + CW'(1);
              end
            end else begin
              row_next = row_reg + RW'(1);
            end
          end else begin
            if (row_reg == ROW_LAST) begin
              row_next = SUB_FIRST;
              col_next = col_reg + CW'(1);
            end else begin
              row_next = row_reg + RW'(1);
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == STREAM);
  assign busy      = (state_reg == STREAM);
  assign out_last  = last_beat;
  assign out_row   = row_reg;
  assign out_col   = col_reg;
  assign out_data  = (state_reg == STREAM) ? elem[row_reg][col_reg] : '0;

endmodule

// File: tb/tb_banded_tile_stream_sequencer.sv
// Randomised self-checking bench: three builds (default, single band, 2x3 with
// one upper row) checked against an arithmetic model of the banded order.
module tb_banded_tile_stream_sequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] in_flat = '0;
  logic         in_valid = 1'b0;
  logic         in_valid8 = 1'b0;
  logic         in_valid_s = 1'b0;
  logic         out_ready = 1'b0;

  logic       in_ready, out_last, out_valid, busy;
  logic [3:0] out_data;
  logic [2:0] out_row, out_col;

  logic       in_ready8, out_last8, out_valid8, busy8;
  logic [3:0] out_data8;
  logic [2:0] out_row8, out_col8;

  logic       in_ready_s, out_last_s, out_valid_s, busy_s;
  logic [3:0] out_data_s;
  logic [0:0] out_row_s;
  logic [1:0] out_col_s;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  banded_tile_stream_sequencer #(.BIT_WIDTH(4), .ROWS(8), .COLS(8), .SUB_ROWS(4)) dut (
    .clk(clk), .rst(rst), .in_flat(in_flat), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy));

  banded_tile_stream_sequencer #(.BIT_WIDTH(4), .ROWS(8), .COLS(8), .SUB_ROWS(8)) dut8 (
    .clk(clk), .rst(rst), .in_flat(in_flat), .in_valid(in_valid8), .in_ready(in_ready8),
    .out_data(out_data8), .out_row(out_row8), .out_col(out_col8), .out_last(out_last8),
    .out_valid(out_valid8), .out_ready(out_ready), .busy(busy8));

  banded_tile_stream_sequencer #(.BIT_WIDTH(4), .ROWS(2), .COLS(3), .SUB_ROWS(1)) dut_s (
    .clk(clk), .rst(rst), .in_flat(in_flat[23:0]), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .out_data(out_data_s), .out_row(out_row_s), .out_col(out_col_s), .out_last(out_last_s),
    .out_valid(out_valid_s), .out_ready(out_ready), .busy(busy_s));

  // Beat k -> (row, col): upper band fills sub*cols beats column by column,
  // the remaining beats walk the lower band the same way.
  function automatic void beat_rc(input int k, input int rows, input int cols,
                                  input int sub, output int r, output int c);
    int upper, j, lb;
    upper = sub * cols;
    if (k < upper) begin
      c = k / sub;
      r = k % sub;
    end else begin
      j  = k - upper;
      lb = rows - sub;
      c  = j / lb;
      r  = sub + j % lb;
    end
  endfunction

  function automatic logic [3:0] elem_of(input logic [255:0] t, input int r, input int c,
                                         input int cols);
    logic [255:0] s;
    s = t >> ((r * cols + c) * 4);
    return s[3:0];
  endfunction

  function automatic logic [255:0] rand_tile();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
    return t;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 ||
        out_data !== 4'd0 || out_row !== 3'd0 || out_col !== 3'd0) begin
      failures++;
      $display("FAIL reset got rdy=%b vld=%b last=%b busy=%b data=%h row=%0d col=%0d exp 1 0 0 0 0 0 0",
               in_ready, out_valid, out_last, busy, out_data, out_row, out_col);
    end
    $display("reset: rdy=%b vld=%b busy=%b", in_ready, out_valid, busy);
  endtask

  // Streams one tile through the default build, checking every presented beat.
  task automatic stream_main(input logic [255:0] tile, input int stall_pct,
                             input bit scramble, input int abort_at, input string name);
    int k, cyc, r, c;
    bit rdy;
    logic [255:0] second;
    k = 0; cyc = 0;
    while (in_ready !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_start in_ready got=%b exp=1", name, in_ready);
    end
    in_flat = tile; in_valid = 1'b1;
    @(negedge clk);
    if (!scramble) in_valid = 1'b0;
    cyc = 0;
    while (k < 64 && cyc < 4000) begin
      beat_rc(k, 8, 8, 4, r, c);
      checks++;
      if (out_valid !== 1'b1 || out_data !== elem_of(tile, r, c, 8) || out_row !== r[2:0] ||
          out_col !== c[2:0] || out_last !== (k == 63) || in_ready !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL %s_beat%0d got vld=%b data=%h (%0d,%0d) last=%b rdy=%b busy=%b exp 1 %h (%0d,%0d) %b 0 1",
                 name, k, out_valid, out_data, out_row, out_col, out_last, in_ready, busy,
                 elem_of(tile, r, c, 8), r, c, (k == 63));
      end
      if (k == abort_at) begin
        rst = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
          failures++;
          $display("FAIL %s_abort got vld=%b rdy=%b busy=%b exp 0 1 0", name, out_valid, in_ready, busy);
        end
        $display("%s: reset at beat %0d", name, k);
        return;
      end
      rdy = ($urandom_range(99) >= stall_pct);
      out_ready = rdy;
      if (scramble) in_flat = rand_tile();
      @(negedge clk);
      cyc++;
      if (rdy) k++;
    end
    checks++;
    if (k != 64) begin
      failures++;
      $display("FAIL %s_timeout beats got=%0d exp=64", name, k);
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_end got vld=%b last=%b rdy=%b busy=%b exp 0 0 1 0",
               name, out_valid, out_last, in_ready, busy);
    end
    if (scramble) begin
      second = in_flat;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== elem_of(second, 0, 0, 8) ||
          out_row !== 3'd0 || out_col !== 3'd0) begin
        failures++;
        $display("FAIL %s_second got vld=%b data=%h (%0d,%0d) exp 1 %h (0,0)",
                 name, out_valid, out_data, out_row, out_col, elem_of(second, 0, 0, 8));
      end
      in_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
    $display("%s: %0d beats in %0d cycles", name, k, cyc);
  endtask

  task automatic test_basic(output logic [255:0] tile);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) tile[(r*8+c)*4 +: 4] = 4'((r * 8 + c) & 15);
    stream_main(tile, 0, 1'b0, -1, "basic");
  endtask

  task automatic test_stall(input logic [255:0] tile);
    stream_main(tile, 50, 1'b0, -1, "stall");
  endtask

  task automatic test_reset_mid();
    stream_main(rand_tile(), 20, 1'b0, 20, "abort");
    stream_main(rand_tile(), 0, 1'b0, -1, "after_abort");
  endtask

  task automatic test_in_valid_hold();
    stream_main(rand_tile(), 30, 1'b1, -1, "hold_valid");
  endtask

  task automatic test_full_band();
    logic [255:0] tile;
    int k, cyc, r, c;
    tile = rand_tile();
    @(negedge clk);
    in_flat = tile; in_valid8 = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    k = 0; cyc = 0;
    while (k < 64 && cyc < 200) begin
      beat_rc(k, 8, 8, 8, r, c);
      checks++;
      if (out_valid8 !== 1'b1 || out_data8 !== elem_of(tile, r, c, 8) || out_row8 !== r[2:0] ||
          out_col8 !== c[2:0] || out_last8 !== (k == 63)) begin
        failures++;
        $display("FAIL full_band_beat%0d got vld=%b data=%h (%0d,%0d) last=%b exp 1 %h (%0d,%0d) %b",
                 k, out_valid8, out_data8, out_row8, out_col8, out_last8,
                 elem_of(tile, r, c, 8), r, c, (k == 63));
      end
      @(negedge clk);
      cyc++; k++;
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || busy8 !== 1'b0) begin
      failures++;
      $display("FAIL full_band_end got vld=%b rdy=%b busy=%b exp 0 1 0", out_valid8, in_ready8, busy8);
    end
    $display("full_band: %0d beats", k);
  endtask

  task automatic test_small();
    logic [255:0] tile;
    int k, r, c;
    tile = '0;
    tile[23:0] = 24'($urandom);
    @(negedge clk);
    in_flat = tile; in_valid_s = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid_s = 1'b0;
    for (k = 0; k < 6; k++) begin
      beat_rc(k, 2, 3, 1, r, c);
      checks++;
      if (out_valid_s !== 1'b1 || out_data_s !== elem_of(tile, r, c, 3) || out_row_s !== r[0:0] ||
          out_col_s !== c[1:0] || out_last_s !== (k == 5)) begin
        failures++;
        $display("FAIL small_beat%0d got vld=%b data=%h (%0d,%0d) last=%b exp 1 %h (%0d,%0d) %b",
                 k, out_valid_s, out_data_s, out_row_s, out_col_s, out_last_s,
                 elem_of(tile, r, c, 3), r, c, (k == 5));
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid_s !== 1'b0 || in_ready_s !== 1'b1 || busy_s !== 1'b0) begin
      failures++;
      $display("FAIL small_end got vld=%b rdy=%b busy=%b exp 0 1 0", out_valid_s, in_ready_s, busy_s);
    end
    $display("small: 6 beats");
  endtask

  initial begin
    logic [255:0] base_tile;
    test_reset();
    test_basic(base_tile);
    test_stall(base_tile);
    test_reset_mid();
    test_in_valid_hold();
    test_full_band();
    test_small();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
